bind_xor_monitor: RTL and testbench
===================================

// Module: bind_xor_monitor
// PURPOSE
//  Bindable, parametrised checker for XOR-style datapaths. Intended to be bound into a host
//  module with `bind`, with MODE forwarded from the host's own parameter. Recomputes each
//  channel's expected output from the host inputs and delays it by the host pipeline depth.
//  Compares the result against the host output, counts mismatches per channel and latches
//  a sticky failure.
// PARAMETERS
//  WIDTH    8  bits per channel
//  CHANNELS 4  independent channels, flattened channel-major (ch0 in LSBs)
//  MODE     1  0: expect zero, 1: expect a^b, 2: expect ~(a^b); other values are an elaboration error
//  LAT      1  host pipeline depth in cycles (0..15); expected value is delayed by LAT
//  CNT_W    8  per-channel mismatch counter width, saturating
// PORTS
//  clk           in   1                  clock, rising edge
//  rst_n         in   1                  asynchronous active-low reset
//  en            in   1                  monitor enable
//  clr           in   1                  synchronous clear of counters, flags and state
//  in_valid      in   1                  host inputs a/b valid this cycle
//  a             in   CHANNELS*WIDTH     host operand a
//  b             in   CHANNELS*WIDTH     host operand b
//  c             in   CHANNELS*WIDTH     host output under check (sampled LAT cycles after a/b)
//  exp_q         out  CHANNELS*WIDTH     delayed expected value
//  exp_valid     out  1                  exp_q is qualified this cycle
//  mismatch_mask out  CHANNELS           registered per-channel mismatch of the last compare
//  err_flag      out  1                  sticky: set while in state FAIL
//  first_ch      out  $clog2(CHANNELS)   index of the lowest failing channel at first failure
//  err_cnt       out  CHANNELS*CNT_W     per-channel saturating mismatch counts
//  state_o       out  2                  current FSM state
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): every output and every internal register is 0.
//    state_o = IDLE.
//  - Expected value per channel: MODE0 -> 0; MODE1 -> a^b; MODE2 -> ~(a^b).
//    Computed combinationally from a/b.
//  - Delay line: expected value and in_valid pass through LAT register stages.
//    The output of the delay line drives exp_q/exp_valid.
//    LAT=0: exp_q = the combinational expected value; exp_valid = in_valid & en.
//  - Compare: when exp_valid & state != IDLE, channel i mismatches iff c[i] != exp_q[i].
//    Registered into mismatch_mask next cycle. mismatch_mask is 0 on cycles with no compare.
//  - Counter i increments by 1 on each mismatch and saturates at 2^CNT_W-1 (no wrap).
//  - FSM states:
//    IDLE(0)  -> ARMED  when en.
//    ARMED(1) -> FAIL   on the first cycle with any mismatch.
//                       first_ch takes the lowest set index; err_flag goes to 1.
//    ARMED(1) -> IDLE   when en is deasserted.
//    FAIL(2)  -> FAIL   until clr; en deassertion does not leave FAIL.
//                       Counting continues in FAIL; first_ch holds.
//  - en low: delay-line valid bits are cleared every cycle, so the pipeline flushes.
//    Data bits may hold stale values; no compares occur.
//  - clr (any state): next cycle state=IDLE, counters/mask/first_ch/err_flag = 0,
//    delay-line valids cleared. clr wins over a same-cycle mismatch and over en.
//  - Compare and en rise in the same cycle: there is no compare that cycle because
//    state is still IDLE. The first possible compare is one cycle after ARMED is entered.
//  - Reset asserted mid-operation: immediate return to the reset values.
//    The pipeline contents are discarded.
// STRUCTURE
//  - Package bind_mon_pkg:
//    typedef enum logic [1:0] {IDLE, ARMED, FAIL} mon_state_t;
//    localparams MODE_ZERO=0, MODE_XOR=1, MODE_XNOR=2; function expected(mode, a, b).
//  - Sub-module bind_mon_delay #(WIDTH*CHANNELS, LAT): data+valid shift line with an
//    async reset and a sync flush input; LAT=0 is a pass-through.
//  - Top level: per-channel compare and counters in a generate loop, the FSM, and a
//    priority encoder for first_ch.
// TESTING
//  1 Defaults, MODE1, LAT1, en=1, a=0x0F/b=0xF0 on all channels, c follows 1 cycle later:
//    c=0xFF -> mismatch_mask=0, err_flag=0, state_o=ARMED.
//  2 As test 1, but ch2 c=0xFE -> mismatch_mask=4'b0100 and err_flag=1 the next cycle;
//    first_ch=2 and err_cnt[ch2]=1.
//  3 MODE0, a=0xAA/b=0x55, c=0 -> no mismatch. Then c[ch1]=0x01 for 300 cycles ->
//    err_cnt[ch1] saturates at 255; first_ch=1.
//  4 LAT=3, MODE2, inputs held one pulse: exp_valid asserts exactly 3 cycles later with
//    exp_q=~(a^b). Drop en for 1 cycle mid-flight -> the pulse never validates.
//  5 In FAIL, assert clr while ch0 also mismatches -> next cycle state_o=IDLE, all
//    counters 0, err_flag=0.
//  6 Bind two instances into a host with MODE 0 and MODE 1 (host outputs 0 and a^b).
//    Random a/b for 1000 cycles -> both err_flag stay 0. Pulse rst_n low mid-run ->
//    all outputs read 0 in the same cycle.

Source files
------------

// File: rtl/bind_mon_pkg.sv
// Shared types and the per-bit expected-value rule for the bindable XOR datapath monitor.
package bind_mon_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FAIL = 2'd2} mon_state_t;

    localparam int MODE_ZERO = 0;
    localparam int MODE_XOR  = 1;
    localparam int MODE_XNOR = 2;

    // Bit-level so any channel width can be built by looping over the flattened bus.
    function automatic logic expected(input int mode, input logic a, input logic b);
        case (mode)
            MODE_XOR:  return a ^ b;
            MODE_XNOR: return ~(a ^ b);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bind_mon_delay.sv
// Data + valid shift line matching the host pipeline depth; flush drops in-flight valids only.
module bind_mon_delay #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         vin,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         vout
);

    if (LAT == 0) begin : g_thru
        assign dout = din;
        assign vout = vin;
    end else begin : g_pipe
        logic [LAT:1]        vld_pipe;
        logic [LAT:1][W-1:0] data_pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_pipe  <= '0;
                data_pipe <= '0;
            end else begin
                vld_pipe[1]  <= vin & ~flush;
                data_pipe[1] <= din;
                for (int i = 2; i <= LAT; i++) begin
                    vld_pipe[i]  <= vld_pipe[i-1] & ~flush;
                    data_pipe[i] <= data_pipe[i-1];
                end
            end
        end

        assign dout = data_pipe[LAT];
        assign vout = vld_pipe[LAT];
    end

endmodule

// File: rtl/bind_xor_monitor.sv
// Bindable checker: recomputes each channel's XOR-family result, delays it by the host
// latency, compares against the host output, counts mismatches and latches a sticky failure.
module bind_xor_monitor
    import bind_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 1,
    parameter int LAT      = 1,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int N       = WIDTH * CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [N-1:0]              a,
    input  logic [N-1:0]              b,
    input  logic [N-1:0]              c,
    output logic [N-1:0]              exp_q,
    output logic                      exp_valid,
    output logic [CHANNELS-1:0]       mismatch_mask,
    output logic                      err_flag,
    output logic [CH_W-1:0]           first_ch,
    output logic [CHANNELS*CNT_W-1:0] err_cnt,
    output logic [1:0]                state_o
);

    if (MODE < MODE_ZERO || MODE > MODE_XNOR) begin : g_bad_mode
        $error("bind_xor_monitor: unsupported MODE %0d", MODE);
    end
    if (LAT < 0 || LAT > 15) begin : g_bad_lat
        $error("bind_xor_monitor: LAT %0d outside 0..15", LAT);
    end

    mon_state_t                       state;
    logic [N-1:0]                     exp_comb;
    logic [N-1:0]                     dly_q;
    logic                             dly_vld;
    logic                             cmp;
    logic [CHANNELS-1:0]              mis;
    logic [CHANNELS-1:0][CNT_W-1:0]   cnt_q;
    logic [CH_W-1:0]                  low_idx;

    always_comb begin
        exp_comb = '0;
        for (int j = 0; j < N; j++) exp_comb[j] = expected(MODE, a[j], b[j]);
    end

    bind_mon_delay #(.W(N), .LAT(LAT)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (~en | clr),
        .vin   (in_valid & en),
        .din   (exp_comb),
        .dout  (dly_q),
        .vout  (dly_vld)
    );

    // Gating with en keeps a stale head-of-line valid from comparing during the flush cycle.
    assign exp_q     = dly_q;
    assign exp_valid = dly_vld & en;
    assign cmp       = exp_valid & (state != IDLE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign mis[i] = cmp & (c[i*WIDTH +: WIDTH] != dly_q[i*WIDTH +: WIDTH]);
    end

    always_comb begin
        low_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) if (mis[i]) low_idx = CH_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_mask <= '0;
            cnt_q         <= '0;
        end else if (clr) begin
            mismatch_mask <= '0;
            cnt_q         <= '0;
        end else begin
            mismatch_mask <= mis;
            for (int i = 0; i < CHANNELS; i++)
                if (mis[i] && cnt_q[i] != {CNT_W{1'b1}}) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_flag <= 1'b0;
            first_ch <= '0;
        end else if (clr) begin
            state    <= IDLE;
            err_flag <= 1'b0;
            first_ch <= '0;
        end else begin
            case (state)
                IDLE:  if (en) state <= ARMED;
                ARMED: begin
                    if (|mis) begin
                        state    <= FAIL;
                        err_flag <= 1'b1;
                        first_ch <= low_idx;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                FAIL:  ;
                default: state <= IDLE;
            endcase
        end
    end

    assign err_cnt = cnt_q;
    assign state_o = state;

endmodule

// File: tb/tb_bind_xor_monitor.sv
// Three monitor instances (XOR/LAT1, ZERO/LAT1, XNOR/LAT3) driven by a bench-side host,
// checked every cycle against a history-based reference plus directed corner sequences.
module tb_bind_xor_monitor;

    localparam int NH        = 8192;
    localparam int MODE_K[3] = '{1, 0, 2};
    localparam int LAT_K[3]  = '{1, 1, 3};

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] c_in [3];
    logic [31:0] eq_o [3];
    logic        ev_o [3];
    logic [3:0]  mm_o [3];
    logic        ef_o [3];
    logic [1:0]  fc_o [3];
    logic [31:0] ec_o [3];
    logic [1:0]  st_o [3];

    int total = 0, bad = 0, cyc = 0, rst_cyc = 0;

    logic [31:0] h_a [NH];
    logic [31:0] h_b [NH];
    bit          h_iv [NH];
    bit          h_en [NH];
    bit          h_clr [NH];

    int          m_st [3];
    logic [3:0]  m_mask [3];
    bit          m_flag [3];
    int          m_fch [3];
    int          m_cnt [3][4];

    typedef struct {
        bit          en;
        bit          iv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] c;
        logic [3:0]  mask;
        logic [1:0]  st;
        bit          flag;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_mon
        bind_xor_monitor #(.WIDTH(8), .CHANNELS(4), .MODE(MODE_K[k]), .LAT(LAT_K[k]), .CNT_W(8)) u_mon (
            .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
            .a(a), .b(b), .c(c_in[k]),
            .exp_q(eq_o[k]), .exp_valid(ev_o[k]), .mismatch_mask(mm_o[k]), .err_flag(ef_o[k]),
            .first_ch(fc_o[k]), .err_cnt(ec_o[k]), .state_o(st_o[k]));
    end

    function automatic logic [31:0] rep(input logic [7:0] x);
        return {4{x}};
    endfunction

    function automatic logic [31:0] hist_x(input int t);
        if (t < 0) return '0;
        return h_a[t & (NH-1)] ^ h_b[t & (NH-1)];
    endfunction

    // Expected value for cycle t comes from the operands LAT cycles earlier.
    function automatic logic [31:0] model_exp(input int k, input int t);
        logic [31:0] x;
        x = hist_x(t - LAT_K[k]);
        case (MODE_K[k])
            0:       return '0;
            1:       return x;
            default: return ~x;
        endcase
    endfunction

    // A pulse survives only if en stayed high and no clr/reset hit it while in flight.
    function automatic bit model_valid(input int k, input int t);
        int s0;
        s0 = t - LAT_K[k];
        if (s0 < rst_cyc) return 1'b0;
        if (!h_iv[s0 & (NH-1)]) return 1'b0;
        for (int s = s0; s <= t; s++) if (!h_en[s & (NH-1)]) return 1'b0;
        for (int s = s0; s < t; s++) if (h_clr[s & (NH-1)]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic record(input int t);
        h_a[t & (NH-1)]   = a;
        h_b[t & (NH-1)]   = b;
        h_iv[t & (NH-1)]  = in_valid;
        h_en[t & (NH-1)]  = en;
        h_clr[t & (NH-1)] = clr;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_mask[k] = '0; m_flag[k] = 1'b0; m_fch[k] = 0;
            for (int ch = 0; ch < 4; ch++) m_cnt[k][ch] = 0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] e;
            logic [3:0]  mis;
            int          low;
            e   = model_exp(k, cyc);
            mis = '0;
            low = 0;
            if (model_valid(k, cyc) && m_st[k] != 0)
                for (int ch = 0; ch < 4; ch++) if (c_in[k][ch*8 +: 8] != e[ch*8 +: 8]) mis[ch] = 1'b1;
            for (int ch = 3; ch >= 0; ch--) if (mis[ch]) low = ch;
            if (clr) begin
                m_st[k] = 0; m_mask[k] = '0; m_flag[k] = 1'b0; m_fch[k] = 0;
                for (int ch = 0; ch < 4; ch++) m_cnt[k][ch] = 0;
            end else begin
                m_mask[k] = mis;
                for (int ch = 0; ch < 4; ch++) if (mis[ch] && m_cnt[k][ch] < 255) m_cnt[k][ch]++;
                case (m_st[k])
                    0: if (en) m_st[k] = 1;
                    1: if (mis != 0) begin m_st[k] = 2; m_flag[k] = 1'b1; m_fch[k] = low; end
                       else if (!en) m_st[k] = 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %h expected %h (cycle %0d)", k, nm, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 3; k++) begin
            bit v;
            v = model_valid(k, cyc);
            chk(k, "state", st_o[k], m_st[k]);
            chk(k, "mask", mm_o[k], m_mask[k]);
            chk(k, "err_flag", ef_o[k], m_flag[k]);
            chk(k, "first_ch", fc_o[k], m_fch[k]);
            for (int ch = 0; ch < 4; ch++) chk(k, "err_cnt", ec_o[k][ch*8 +: 8], m_cnt[k][ch]);
            chk(k, "exp_valid", ev_o[k], v);
            if (v) chk(k, "exp_q", eq_o[k], model_exp(k, cyc));
        end
    endtask

    task automatic chk_zero(input int k);
        chk(k, "rst_exp_q", eq_o[k], 0);
        chk(k, "rst_exp_valid", ev_o[k], 0);
        chk(k, "rst_mask", mm_o[k], 0);
        chk(k, "rst_flag", ef_o[k], 0);
        chk(k, "rst_first_ch", fc_o[k], 0);
        chk(k, "rst_cnt", ec_o[k], 0);
        chk(k, "rst_state", st_o[k], 0);
    endtask

    // Inputs are final for the closing cycle; the post-edge record is provisional for the next.
    task automatic tick();
        record(cyc);
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        record(cyc);
        model_check();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk_zero(k);
        rst_n = 1'b1;
        model_reset();
        rst_cyc = cyc;
    endtask

    task automatic drive_host(input bit inject);
        in_valid = ($urandom_range(0, 7) != 0);
        a        = $urandom;
        b        = $urandom;
        c_in[0]  = hist_x(cyc - 1);
        c_in[1]  = '0;
        c_in[2]  = ~hist_x(cyc - 3);
        if (inject)
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 19) == 0) c_in[k] ^= (32'h1 << $urandom_range(0, 31));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) c_in[k] = '0;
        tbl[0] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 32'hFFFF_FFFF, 4'b0000, 2'd1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 32'hFFFF_FFFF, 4'b0000, 2'd1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 32'hFFFE_FFFF, 4'b0100, 2'd2, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 8'h0F, 8'hF0, 32'hFFFF_FFFF, 4'b0000, 2'd2, 1'b1};

        #8;
        for (int k = 0; k < 3; k++) chk_zero(k);
        rst_n = 1'b1;
        model_reset();
        record(0);

        // Clean compare, then a single-channel miss on ch2.
        for (int i = 0; i < 4; i++) begin
            en = tbl[i].en; in_valid = tbl[i].iv;
            a = rep(tbl[i].a); b = rep(tbl[i].b); c_in[0] = tbl[i].c;
            tick();
            chk(0, "tbl_mask", mm_o[0], tbl[i].mask);
            chk(0, "tbl_state", st_o[0], tbl[i].st);
            chk(0, "tbl_flag", ef_o[0], tbl[i].flag);
        end
        chk(0, "t2_first_ch", fc_o[0], 2);
        chk(0, "t2_cnt", ec_o[0], 32'h0001_0000);

        // clr beats a same-cycle ch0 mismatch while in FAIL.
        in_valid = 1'b1; a = rep(8'h0F); b = rep(8'hF0); c_in[0] = 32'hFFFF_FFFF;
        tick();
        chk(0, "t5_pre_state", st_o[0], 2);
        clr = 1'b1; c_in[0] = 32'hFFFF_FF00;
        tick();
        clr = 1'b0;
        chk(0, "t5_state", st_o[0], 0);
        chk(0, "t5_cnt", ec_o[0], 0);
        chk(0, "t5_flag", ef_o[0], 0);
        chk(0, "t5_mask", mm_o[0], 0);

        // MODE0 channel stuck at 0x01 saturates its counter.
        a = rep(8'hAA); b = rep(8'h55);
        c_in[0] = 32'hFFFF_FFFF; c_in[1] = '0; c_in[2] = '0;
        repeat (3) tick();
        chk(1, "t3_mask", mm_o[1], 0);
        chk(1, "t3_state", st_o[1], 1);
        c_in[1] = 32'h0000_0100;
        repeat (300) tick();
        chk(1, "t3_cnt", ec_o[1], 32'h0000_FF00);
        chk(1, "t3_first_ch", fc_o[1], 1);
        chk(1, "t3_flag", ef_o[1], 1);

        // LAT3 XNOR pulse timing, then a pulse killed by an en drop.
        clr = 1'b1; tick(); clr = 1'b0;
        a = rep(8'h3C); b = rep(8'h0F); c_in[2] = 32'hCCCC_CCCC; in_valid = 1'b1;
        tick(); chk(2, "t4_ev_d1", ev_o[2], 0);
        in_valid = 1'b0; a = '0; b = '0;
        tick(); chk(2, "t4_ev_d2", ev_o[2], 0);
        tick(); chk(2, "t4_ev_d3", ev_o[2], 1); chk(2, "t4_exp_q", eq_o[2], 32'hCCCC_CCCC);
        tick(); chk(2, "t4_ev_d4", ev_o[2], 0);
        a = rep(8'h3C); b = rep(8'h0F); in_valid = 1'b1;
        tick();
        in_valid = 1'b0; en = 1'b0;
        tick();
        en = 1'b1;
        tick(); chk(2, "t4_flush_d3", ev_o[2], 0);
        tick(); chk(2, "t4_flush_d4", ev_o[2], 0);

        // Well-behaved host with random traffic and an asynchronous reset mid-run.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            drive_host(1'b0);
            tick();
            if (i == 499) begin
                for (int k = 0; k < 3; k++) chk(k, "t6_flag_mid", ef_o[k], 0);
                pulse_reset();
            end
        end
        for (int k = 0; k < 3; k++) chk(k, "t6_flag_end", ef_o[k], 0);

        // Faulty host, random en/clr, scored by the reference only.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 49) == 0);
            drive_host(1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
